// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD1602 message arbiter.
// Message codes match the sel_msg table of the LCD text controller.
package lcd_pkg;

  localparam logic [1:0] MSG_USER     = 2'b00;
  localparam logic [1:0] MSG_KEY      = 2'b01;
  localparam logic [1:0] MSG_OPEN     = 2'b10;
  localparam logic [1:0] MSG_INTRUDER = 2'b11;

  localparam logic [7:0] NO_DIGIT = 8'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ANNOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/lcd_arb_pick.sv
// Combinational winner select for the LCD arbiter.
// LCD_ARB_RR_EN: round-robin from ptr_i; otherwise highest index wins.
module lcd_arb_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifdef LCD_ARB_RR_EN
  input  logic [IW-1:0]      ptr_i,
`endif
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IW-1:0]      win_idx_o,
  output logic               valid_o
);

`ifdef LCD_ARB_RR_EN
  logic found;
  int   j;
`endif

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = |req_i;
`ifdef LCD_ARB_RR_EN
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        win_idx_o = IW'(j);
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i]) win_idx_o = IW'(i);
    end
`endif
    if (valid_o) win_oh_o[win_idx_o] = 1'b1;
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares one LCD1602 controller between NUM_REQ requesters.
// Define LCD_ARB_RR_EN for round-robin, else fixed highest-index priority.
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         CHG_CYCLES  = 1_600_000,
  parameter int         HOLD_CYCLES = 50_000_000,
  parameter logic [1:0] DEFAULT_MSG = MSG_USER
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [2*NUM_REQ-1:0] msg_i,
  input  logic [4*NUM_REQ-1:0] digit_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [1:0]           sel_msg,
  output logic                 message_change,
  output logic [7:0]           data_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CHG_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CHG_LAST  = CW'(CHG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [1:0]          sel_q;
  logic                chg_q;
  logic [7:0]          data_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       chg_cnt_q;
  logic [HW-1:0]       hold_cnt_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic [IW-1:0]       win_idx;
  logic                win_vld;
  logic                keep;
  logic [3:0]          dig;

`ifdef LCD_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  assign ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
`endif

  lcd_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i     (req_i),
`ifdef LCD_ARB_RR_EN
    .ptr_i     (ptr_q),
`endif
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .valid_o   (win_vld)
  );

  assign keep = req_i[idx_q];
  assign dig  = digit_i[{idx_q, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      sel_q      <= DEFAULT_MSG;
      chg_q      <= 1'b0;
      data_q     <= NO_DIGIT;
      idx_q      <= '0;
      chg_cnt_q  <= '0;
      hold_cnt_q <= '0;
`ifdef LCD_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q   <= ANNOUNCE;
            gnt_q     <= win_oh;
            idx_q     <= win_idx;
            sel_q     <= msg_i[{win_idx, 1'b0} +: 2];
            chg_q     <= 1'b1;
            chg_cnt_q <= '0;
          end
        end
        ANNOUNCE: begin
          if (!keep) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            chg_q   <= 1'b0;
            data_q  <= NO_DIGIT;
          end else begin
            data_q <= {4'h0, dig};
            if (chg_cnt_q == CHG_LAST) begin
              state_q    <= HOLD;
              chg_q      <= 1'b0;
              hold_cnt_q <= '0;
            end else begin
              chg_cnt_q <= chg_cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (!keep) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            data_q  <= NO_DIGIT;
          end else if (hold_cnt_q == HOLD_LAST) begin
            // keep is known high here, so done goes to the winner
            state_q <= RELEASE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            data_q  <= NO_DIGIT;
          end else begin
            data_q     <= {4'h0, dig};
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        RELEASE: begin
          state_q <= IDLE;
`ifdef LCD_ARB_RR_EN
          ptr_q   <= ptr_d;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o          = gnt_q;
  assign done_o         = done_q;
  assign sel_msg        = sel_q;
  assign message_change = chg_q;
  assign data_o         = data_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter (CHG=4, HOLD=10, NUM_REQ=4).
// Grant/done events are queued by stimulus and checked by a monitor.
module tb_lcd_msg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  msg;
  logic [15:0] dig;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [1:0]  sel_msg;
  logic        message_change;
  logic [7:0]  data_o;
  logic        busy_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] val;
    logic [1:0] sel;
    int         at;
  } exp_t;

  exp_t q[$];

  lcd_msg_arbiter #(
    .NUM_REQ     (4),
    .CHG_CYCLES  (4),
    .HOLD_CYCLES (10),
    .DEFAULT_MSG (2'b00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req),
    .msg_i          (msg),
    .digit_i        (dig),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .sel_msg        (sel_msg),
    .message_change (message_change),
    .data_o         (data_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input bit d, input logic [3:0] v,
                      input logic [1:0] s, input int at);
    exp_t x;
    x.is_done = d;
    x.val     = v;
    x.sel     = s;
    x.at      = at;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  logic [3:0] prev_gnt = 4'b0;

  always @(negedge clk) begin
    exp_t x;
    if (gnt_o != 4'b0 && prev_gnt == 4'b0) begin
      if (q.size() == 0) begin
        chk("grant_unexpected", 32'(gnt_o), 32'd0);
      end else begin
        x = q.pop_front();
        chk("grant_order", 32'(x.is_done), 32'd0);
        chk("grant_val", 32'(gnt_o), 32'(x.val));
        chk("grant_sel", 32'(sel_msg), 32'(x.sel));
        chk("grant_cycle", 32'(cyc), 32'(x.at));
        chk("grant_chg", 32'(message_change), 32'd1);
      end
    end
    if (done_o != 4'b0) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        x = q.pop_front();
        chk("done_order", 32'(x.is_done), 32'd1);
        chk("done_val", 32'(done_o), 32'(x.val));
        chk("done_cycle", 32'(cyc), 32'(x.at));
        chk("done_gnt", 32'(gnt_o), 32'd0);
      end
    end
    prev_gnt = gnt_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int first;
    int second;

    reset = 1'b1;
    req   = 4'b0;
    msg   = 8'b0;
    dig   = 16'hFFFF;
    repeat (3) step();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sel", 32'(sel_msg), 32'd0);
    chk("rst_chg", 32'(message_change), 32'd0);
    chk("rst_data", 32'(data_o), 32'd15);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    step();

    // two simultaneous requesters: 0 and 3
`ifdef LCD_ARB_RR_EN
    first  = 0;
    second = 3;
`else
    first  = 3;
    second = 0;
`endif
    msg = 8'b11_00_00_01;
    dig = 16'h5FF2;
    req = 4'b1001;
    e   = cyc + 1;
    push(1'b0, 4'(1 << first), msg[2*first +: 2], e);
    push(1'b1, 4'(1 << first), 2'b00, e + 14);
    push(1'b0, 4'(1 << second), msg[2*second +: 2], e + 16);
    push(1'b1, 4'(1 << second), 2'b00, e + 30);
    wait_until(e + 14);
    req[first] = 1'b0;
    wait_until(e + 30);
    req = 4'b0;
    repeat (3) step();

    // single request, digit tracking, normal release
    msg = 8'b00_10_00_00;
    dig = 16'hF3FF;
    req = 4'b0100;
    e   = cyc + 1;
    push(1'b0, 4'b0100, 2'b10, e);
    push(1'b1, 4'b0100, 2'b00, e + 14);
    wait_until(e + 3);
    chk("chg_last_hi", 32'(message_change), 32'd1);
    wait_until(e + 4);
    chk("chg_end", 32'(message_change), 32'd0);
    chk("hold_busy", 32'(busy_o), 32'd1);
    chk("hold_data3", 32'(data_o), 32'd3);
    dig = 16'hF7FF;
    wait_until(e + 5);
    chk("hold_data7", 32'(data_o), 32'd7);
    wait_until(e + 14);
    chk("rel_data", 32'(data_o), 32'd15);
    req = 4'b0;
    wait_until(e + 15);
    chk("rel_sel_kept", 32'(sel_msg), 32'd2);
    chk("idle_busy", 32'(busy_o), 32'd0);
    repeat (3) step();

    // winner 3 withdraws in HOLD; pending requester 0 follows
    msg = 8'b01_00_00_10;
    dig = 16'h4FF1;
    req = 4'b1001;
    e   = cyc + 1;
    push(1'b0, 4'b1000, 2'b01, e);
    push(1'b0, 4'b0001, 2'b10, e + 8);
    push(1'b1, 4'b0001, 2'b00, e + 22);
    wait_until(e + 5);
    req[3] = 1'b0;
    wait_until(e + 6);
    chk("wd_gnt", 32'(gnt_o), 32'd0);
    chk("wd_done", 32'(done_o), 32'd0);
    chk("wd_busy", 32'(busy_o), 32'd1);
    chk("wd_data", 32'(data_o), 32'd15);
    wait_until(e + 7);
    chk("wd_idle", 32'(busy_o), 32'd0);
    wait_until(e + 22);
    req = 4'b0;
    repeat (3) step();

    // reset during ANNOUNCE
    msg = 8'b00_11_00_00;
    dig = 16'hF9FF;
    req = 4'b0100;
    e   = cyc + 1;
    push(1'b0, 4'b0100, 2'b11, e);
    wait_until(e + 1);
    reset = 1'b1;
    wait_until(e + 2);
    chk("mr_chg", 32'(message_change), 32'd0);
    chk("mr_gnt", 32'(gnt_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_done", 32'(done_o), 32'd0);
    chk("mr_sel", 32'(sel_msg), 32'd0);
    chk("mr_data", 32'(data_o), 32'd15);
    reset = 1'b0;
    req   = 4'b0;
    repeat (5) step();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
